// File: rtl/synth_spi_write_scheduler.sv
// -----------------------------------------------------------------------------
// synth_spi_write_scheduler
//
// Purpose:
//   SPI-slave (mode 0) front end that turns 32-bit host frames into single-cycle
//   register writes on the synth register bus. Each frame carries the register
//   number in bits [31:16] and the value in bits [15:0]. The three SPI inputs
//   are resynchronised into i_Clock, deserialised, and queued in a small FIFO.
//   An issue FSM then drains the FIFO one write per cycle. This block is the
//   only configuration path into the core register file, so host SPI timing is
//   fully decoupled from the core clock.
//
// Optional feature (macro SYNTH_WRITE_SYNC_EN):
//   When defined, queued writes are held until the core signals a sample
//   boundary on i_SampleReady. The whole FIFO is then drained in one burst,
//   including frames that arrive during the drain. When undefined,
//   i_SampleReady is ignored and writes issue as soon as they are queued.
//
// Parameters:
//   FIFO_DEPTH   frame buffer entries (power of two, >= 2)
//   SYNC_STAGES  flip-flop stages on each SPI input synchroniser (>= 2)
//
// Ports:
//   i_Clock                system clock, shared with synth/core
//   i_Reset_n              asynchronous active-low reset
//   i_SpiClock             SPI SCLK, mode 0, at most i_Clock/4
//   i_SpiChipSelect_n      SPI chip select, active low
//   i_SpiMosi              SPI data in, MSB first
//   i_SampleReady          core sample-boundary pulse (1 cycle)
//   o_RegisterNumber[15:0] register number to synth (held between strobes)
//   o_RegisterValue[15:0]  register value to synth (held between strobes)
//   o_RegisterWriteEnable  one-cycle write strobe to synth
//   o_Overflow             sticky: a frame was dropped because the FIFO was full
//   o_Busy                 FIFO non-empty or a write is in flight
// -----------------------------------------------------------------------------
module synth_spi_write_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SpiClock,
  input  logic        i_SpiChipSelect_n,
  input  logic        i_SpiMosi,
  input  logic        i_SampleReady,
  output logic [15:0] o_RegisterNumber,
  output logic [15:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable,
  output logic        o_Overflow,
  output logic        o_Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE          = 2'd0,
    S_WAIT_BOUNDARY = 2'd1,
    S_DRAIN         = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and SCLK rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_SclkSync;
  logic [SYNC_STAGES-1:0] r_CsSync;
  logic [SYNC_STAGES-1:0] r_MosiSync;
  logic                   r_SclkPrev;
  logic                   w_SclkSynced;
  logic                   w_CsSynced_n;
  logic                   w_MosiSynced;
  logic                   w_SamplePulse;

  // Chip select resets to the deasserted (high) level so that reset behaves
  // like an idle bus rather than the start of a frame.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_SclkSync <= '0;
      r_CsSync   <= '1;
      r_MosiSync <= '0;
      r_SclkPrev <= 1'b0;
    end else begin
      r_SclkSync <= {r_SclkSync[SYNC_STAGES-2:0], i_SpiClock};
      r_CsSync   <= {r_CsSync[SYNC_STAGES-2:0], i_SpiChipSelect_n};
      r_MosiSync <= {r_MosiSync[SYNC_STAGES-2:0], i_SpiMosi};
      r_SclkPrev <= w_SclkSynced;
    end
  end

  assign w_SclkSynced  = r_SclkSync[SYNC_STAGES-1];
  assign w_CsSynced_n  = r_CsSync[SYNC_STAGES-1];
  assign w_MosiSynced  = r_MosiSync[SYNC_STAGES-1];
  // MOSI travels through the same number of stages as SCLK, so the synced
  // data bit is aligned with the synced rising edge.
  assign w_SamplePulse = w_SclkSynced & ~r_SclkPrev;

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  logic [30:0] r_Shift;
  logic [4:0]  r_BitCount;
  logic        r_PushPending;
  logic [31:0] r_FrameData;
  logic        w_FrameDone;

  assign w_FrameDone = w_SamplePulse & ~w_CsSynced_n & (r_BitCount == 5'd31);

  // Only 31 bits are kept in the shifter: the 32nd bit goes straight into the
  // frame register, which holds the frame stable for the following push.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Shift       <= '0;
      r_BitCount    <= '0;
      r_PushPending <= 1'b0;
      r_FrameData   <= '0;
    end else begin
      r_PushPending <= w_FrameDone;
      if (w_FrameDone) begin
        r_FrameData <= {r_Shift, w_MosiSynced};
      end
      if (w_CsSynced_n) begin
        // Deselect abandons any partial frame without flagging it.
        r_BitCount <= '0;
      end else if (w_SamplePulse) begin
        r_Shift    <= {r_Shift[29:0], w_MosiSynced};
        // 5-bit counter wraps 31 -> 0, so streamed bits start the next frame.
        r_BitCount <= r_BitCount + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_WrPtr;
  logic [PTR_W-1:0] r_RdPtr;
  logic [CNT_W-1:0] r_Count;
  logic [31:0]      w_RdData;
  logic             w_Full;
  logic             w_Pop;
  logic             w_PushAccept;
  logic             w_Drop;

  assign w_RdData = r_Mem[r_RdPtr];

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_Mem[i] <= '0;
      end
      r_WrPtr <= '0;
      r_RdPtr <= '0;
      r_Count <= '0;
    end else begin
      if (w_PushAccept) begin
        r_Mem[r_WrPtr] <= r_FrameData;
        r_WrPtr        <= r_WrPtr + PTR_W'(1);
      end
      if (w_Pop) begin
        r_RdPtr <= r_RdPtr + PTR_W'(1);
      end
      case ({w_PushAccept, w_Pop})
        2'b10:   r_Count <= r_Count + C_ONE;
        2'b01:   r_Count <= r_Count - C_ONE;
        default: r_Count <= r_Count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: state register
  // ---------------------------------------------------------------------------
  state_t r_State;
  state_t w_StateNext;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State <= S_IDLE;
    end else begin
      r_State <= w_StateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_StateNext = r_State;
    case (r_State)
      S_IDLE: begin
        if (r_Count != '0) begin
`ifdef SYNTH_WRITE_SYNC_EN
          w_StateNext = S_WAIT_BOUNDARY;
`else
          w_StateNext = S_DRAIN;
`endif
        end
      end
      S_WAIT_BOUNDARY: begin
`ifdef SYNTH_WRITE_SYNC_EN
        if (i_SampleReady) begin
          w_StateNext = S_DRAIN;
        end
`else
        w_StateNext = S_IDLE;
`endif
      end
      S_DRAIN: begin
        // Leave once this cycle's pop empties the FIFO; a push landing in
        // the same cycle keeps the drain going.
        if ((r_Count == '0) || ((r_Count == C_ONE) && !w_PushAccept)) begin
          w_StateNext = S_IDLE;
        end
      end
      default: w_StateNext = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue FSM: output logic (pop / push arbitration)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_Full       = (r_Count == C_FULL);
    w_Pop        = (r_State == S_DRAIN) && (r_Count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the drain is popping.
    w_PushAccept = r_PushPending && (!w_Full || w_Pop);
    w_Drop       = r_PushPending && w_Full && !w_Pop;
  end

`ifndef SYNTH_WRITE_SYNC_EN
  logic w_unused_sample_ready;
  assign w_unused_sample_ready = i_SampleReady;
`endif

  // ---------------------------------------------------------------------------
  // Registered write bus and status
  // ---------------------------------------------------------------------------
  logic [15:0] r_RegisterNumber;
  logic [15:0] r_RegisterValue;
  logic        r_WriteEnable;
  logic        r_Overflow;
  logic        r_Busy;

  // Busy is registered from the current occupancy/state, so it stays high for
  // the strobe cycle of the final write and falls on the cycle after it.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_RegisterNumber <= '0;
      r_RegisterValue  <= '0;
      r_WriteEnable    <= 1'b0;
      r_Overflow       <= 1'b0;
      r_Busy           <= 1'b0;
    end else begin
      r_WriteEnable <= w_Pop;
      if (w_Pop) begin
        r_RegisterNumber <= w_RdData[31:16];
        r_RegisterValue  <= w_RdData[15:0];
      end
      if (w_Drop) begin
        r_Overflow <= 1'b1;
      end
      r_Busy <= (r_Count != '0) || (r_State != S_IDLE);
    end
  end

  assign o_RegisterNumber      = r_RegisterNumber;
  assign o_RegisterValue       = r_RegisterValue;
  assign o_RegisterWriteEnable = r_WriteEnable;
  assign o_Overflow            = r_Overflow;
  assign o_Busy                = r_Busy;

endmodule

// File: doc/synth_spi_write_scheduler.md
Name: synth_spi_write_scheduler

Overview:
SPI-slave front end that turns serial host frames into the synth register-write bus (register number, register value, write enable). It deserialises 32-bit frames, buffers them in a small FIFO and issues them one per cycle as single-cycle write strobes into synth. It is the only configuration path into the core's register file, so host SPI timing is fully decoupled from the core clock domain.

Parameters:
FIFO_DEPTH, 4, frame buffer entries; power of two, at least 2.
SYNC_STAGES, 2, flip-flop stages on each SPI input synchroniser; at least 2.

Ports:
i_Clock  input  1  system clock, shared with synth/core
i_Reset_n  input  1  asynchronous active-low reset
i_SpiClock  input  1  SPI SCLK, mode 0, at most i_Clock/4
i_SpiChipSelect_n  input  1  SPI chip select, active low
i_SpiMosi  input  1  SPI data in, MSB first
i_SampleReady  input  1  core sample-boundary pulse (1 cycle)
o_RegisterNumber  output  16  register number to synth
o_RegisterValue  output  16  register value to synth
o_RegisterWriteEnable  output  1  one-cycle write strobe to synth
o_Overflow  output  1  sticky: a frame was dropped because the FIFO was full
o_Busy  output  1  FIFO non-empty or a write is in flight

Behaviour:
- Reset: the asynchronous assert of i_Reset_n clears all state. All outputs go to 0, the FIFO empties, the bit counter goes to 0 and the FSM goes to IDLE. A reset mid-frame or mid-drain discards the partial frame and all queued frames.
- Synchronisation: SCLK, CS_n and MOSI each pass through SYNC_STAGES flops. A registered rising-edge detector on synced SCLK produces a 1-cycle sample pulse.
- Deserialiser:
  - On each sample pulse while synced CS_n is low: shift MOSI into a 32-bit register and increment a 5-bit counter.
  - When the counter wraps from 31 to 0, the frame is complete: bits [31:16] are the register number and [15:0] the value. The frame is pushed on the next cycle.
  - Streaming: bits after 32 within the same CS low start the next frame.
  - Synced CS_n high clears the counter. A partial frame (fewer than 32 bits) is silently discarded and not flagged.
- FIFO:
  - Width 32, depth FIFO_DEPTH, with wrapping pointers plus a count.
  - Push and pop in the same cycle are allowed, including when full: the pop frees the slot first, so the push is accepted and occupancy is unchanged.
  - A push when full with no pop drops the frame and sets o_Overflow, which stays set until reset.
- Issue FSM (states IDLE, WAIT_BOUNDARY, DRAIN):
  - IDLE to DRAIN when the FIFO is non-empty, or to WAIT_BOUNDARY if the optional feature is enabled.
  - DRAIN: pop one entry per cycle into the registered o_RegisterNumber and o_RegisterValue, with o_RegisterWriteEnable high for exactly that cycle. Back-to-back strobes occur while entries remain.
  - DRAIN returns to IDLE on the cycle after the last pop.
- o_RegisterNumber and o_RegisterValue hold the last issued values between strobes.
- Latency, with the FIFO empty and the feature disabled: o_RegisterWriteEnable rises SYNC_STAGES+3 i_Clock cycles after the i_Clock edge that first samples the 32nd SCLK rise high.
- o_Busy = (FIFO count != 0) or (state != IDLE).

Optional Feature:
Macro SYNTH_WRITE_SYNC_EN.
- Defined: IDLE with a non-empty FIFO goes to WAIT_BOUNDARY. That state holds until i_SampleReady is high, then enters DRAIN on the next cycle. DRAIN empties the entire FIFO, including frames pushed during the drain, so all queued writes land together right after a sample boundary.
- i_SampleReady while IDLE with an empty FIFO has no effect.
- Undefined: WAIT_BOUNDARY is never entered and i_SampleReady is ignored (port retained, unused).

Test Plan:
- Single frame 0x1002_0003, SYNC_STAGES=2, feature off -> exactly one strobe with number 0x1002 and value 0x0003, 5 cycles after the 32nd SCLK rise is sampled. o_Busy falls the cycle after the strobe.
- Three frames streamed in one CS low (0x0100_0001, 0x0101_0005, 0x0A00_1234) -> three strobes in order with matching values. The outputs hold 0x0A00/0x1234 afterwards.
- CS_n raised after 20 bits, then a full frame 0x0200_00FF -> only one strobe (0x0200/0x00FF), and o_Overflow stays 0.
- FIFO_DEPTH=4, issue path held by the feature on with no i_SampleReady, 5 frames sent -> o_Overflow=1. Then one i_SampleReady pulse gives 4 consecutive strobes with the first 4 frames.
- i_Reset_n pulsed low mid-frame (bit 17) and with 2 frames queued -> all outputs 0 immediately, no strobes follow. A subsequent full frame issues normally.
- Feature on, frame queued, i_SampleReady pulsed 100 cycles later -> no strobe before the pulse, and the strobe arrives 2 cycles after it.
